monmult_arbiter: RTL and testbench

//  Shares one Montgomery multiplier engine (GO/A/B/M/P/is_ready interface) between two requesters,
//  e.g. two RSA exponentiation sequencers or an RSA sequencer and a residue precompute unit.

---
 rtl/monmult_arbiter_if.sv | 30 +++
 rtl/monmult_arbiter.sv | 127 ++++++++++++
 tb/tb_monmult_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/monmult_arbiter_if.sv
// Requester and engine-side bus of the Montgomery multiplier arbiter.
// The arbiter uses the slave modport; the requesters/engine environment uses master.
interface monmult_arbiter_if #(
    parameter int unsigned WIDTH = 64
);
    logic [1:0]         req_valid;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*WIDTH-1:0] req_m;
    logic [1:0]         req_ready;
    logic [1:0]         resp_valid;
    logic [WIDTH:0]     resp_p;
    logic               resp_err;
    logic               mm_go;
    logic [WIDTH-1:0]   mm_a;
    logic [WIDTH-1:0]   mm_b;
    logic [WIDTH-1:0]   mm_m;
    logic [WIDTH:0]     mm_p;
    logic               mm_ready;

    modport slave (
        input  req_valid, req_a, req_b, req_m, mm_p, mm_ready,
        output req_ready, resp_valid, resp_p, resp_err, mm_go, mm_a, mm_b, mm_m
    );

    modport master (
        output req_valid, req_a, req_b, req_m, mm_p, mm_ready,
        input  req_ready, resp_valid, resp_p, resp_err, mm_go, mm_a, mm_b, mm_m
    );
endinterface

// File: rtl/monmult_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier engine between two requesters,
// with operand latching, GO sequencing, result return and a RUN watchdog.
module monmult_arbiter #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             pclk,
    input  logic             reset,
    monmult_arbiter_if.slave bus,
    output logic             busy,
    output logic             grant_id
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;

    state_e           state_q, state_d;
    logic             mm_go_q, mm_go_d;
    logic [WIDTH-1:0] mm_a_q, mm_a_d;
    logic [WIDTH-1:0] mm_b_q, mm_b_d;
    logic [WIDTH-1:0] mm_m_q, mm_m_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [WIDTH:0]   resp_p_q, resp_p_d;
    logic             resp_err_q, resp_err_d;
    logic             grant_id_q, grant_id_d;
    logic             rr_q, rr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             win_c;
    logic [1:0]       req_ready_c;

    // Contention goes to the requester not served last; otherwise the lone valid one wins.
    always_comb begin
        if (&bus.req_valid) win_c = rr_q;
        else                win_c = bus.req_valid[1];
    end

    always_comb begin
        state_d      = state_q;
        mm_go_d      = mm_go_q;
        mm_a_d       = mm_a_q;
        mm_b_d       = mm_b_q;
        mm_m_d       = mm_m_q;
        resp_valid_d = 2'b00;
        resp_p_d     = resp_p_q;
        resp_err_d   = resp_err_q;
        grant_id_d   = grant_id_q;
        rr_d         = rr_q;
        timer_d      = timer_q;
        req_ready_c  = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_c[win_c] = 1'b1;
                    mm_a_d     = win_c ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                    mm_b_d     = win_c ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                    mm_m_d     = win_c ? bus.req_m[2*WIDTH-1:WIDTH] : bus.req_m[WIDTH-1:0];
                    grant_id_d = win_c;
                    timer_d    = '0;
                    mm_go_d    = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + TW'(1);
                // Completion takes precedence over a coincident watchdog expiry.
                if (bus.mm_ready && mm_go_q) begin
                    resp_p_d   = bus.mm_p;
                    resp_err_d = 1'b0;
                    mm_go_d    = 1'b0;
                    resp_valid_d[grant_id_q] = 1'b1;
                    state_d    = S_RESP;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    resp_p_d   = '0;
                    resp_err_d = 1'b1;
                    mm_go_d    = 1'b0;
                    resp_valid_d[grant_id_q] = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rr_d    = ~grant_id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mm_go_q      <= 1'b0;
            mm_a_q       <= '0;
            mm_b_q       <= '0;
            mm_m_q       <= '0;
            resp_valid_q <= 2'b00;
            resp_p_q     <= '0;
            resp_err_q   <= 1'b0;
            grant_id_q   <= 1'b0;
            rr_q         <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            mm_go_q      <= mm_go_d;
            mm_a_q       <= mm_a_d;
            mm_b_q       <= mm_b_d;
            mm_m_q       <= mm_m_d;
            resp_valid_q <= resp_valid_d;
            resp_p_q     <= resp_p_d;
            resp_err_q   <= resp_err_d;
            grant_id_q   <= grant_id_d;
            rr_q         <= rr_d;
            timer_q      <= timer_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_p     = resp_p_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mm_go      = mm_go_q;
    assign bus.mm_a       = mm_a_q;
    assign bus.mm_b       = mm_b_q;
    assign bus.mm_m       = mm_m_q;
    assign busy           = (state_q != S_IDLE);
    assign grant_id       = grant_id_q;
endmodule

// File: tb/tb_monmult_arbiter.sv
// Scoreboard bench for monmult_arbiter with a behavioural Montgomery engine (result = A+B).
module tb_monmult_arbiter;
    localparam int unsigned W  = 64;
    localparam int unsigned TO = 255;
    localparam int          L  = 10;

    typedef struct {
        logic         id;
        logic [W:0]   p;
        logic         err;
    } exp_t;

    logic pclk = 1'b0;
    logic reset;
    logic busy;
    logic grant_id;

    always #5 pclk = ~pclk;

    monmult_arbiter_if #(.WIDTH(W)) bus();

    monmult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .pclk     (pclk),
        .reset    (reset),
        .bus      (bus.slave),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int eng_mode = 0;   // 0: ready L cycles after go, 1: never ready, 2: always ready
    int go_run = 0;
    int acc_cyc, resp_cyc;
    logic       o_which;
    logic [1:0] o_v;
    logic [W:0] o_p;
    logic       o_e;
    exp_t       sb[$];

    always @(posedge pclk) cyc <= cyc + 1;

    // Engine model: result appears L cycles after GO rises and drops with GO.
    always @(negedge pclk) begin
        if (bus.mm_go) go_run = go_run + 1;
        else           go_run = 0;
        case (eng_mode)
            1:       bus.mm_ready = 1'b0;
            2:       bus.mm_ready = 1'b1;
            default: bus.mm_ready = bus.mm_go && (go_run > L);
        endcase
        bus.mm_p = {1'b0, W'(bus.mm_a + bus.mm_b)};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] m);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_m[i*W +: W] = m;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_accept(input int max, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge pclk);
            if ((bus.req_ready & bus.req_valid) != 2'b00) begin
                seen    = 1'b1;
                o_which = bus.req_ready[1];
                o_v     = bus.req_ready;
                acc_cyc = cyc;
            end
        end
    endtask

    task automatic wait_resp(input int max, input logic [1:0] drop, output bit seen,
                             output int gocnt);
        seen  = 1'b0;
        gocnt = 0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge pclk);
            if (k == 0) bus.req_valid = bus.req_valid & ~drop;
            if (bus.mm_go) gocnt++;
            if (bus.resp_valid != 2'b00) begin
                seen     = 1'b1;
                resp_cyc = cyc;
                o_v      = bus.resp_valid;
                o_p      = bus.resp_p;
                o_e      = bus.resp_err;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a = '0; bus.req_b = '0; bus.req_m = '0;
        repeat (3) @(negedge pclk);
        n_cmp++; if (busy !== 1'b0 || bus.mm_go !== 1'b0) begin n_bad++;
            $display("FAIL rst_busy_go: got busy=%0b go=%0b want 0 0", busy, bus.mm_go); end
        n_cmp++; if (bus.resp_valid !== 2'b00 || bus.resp_err !== 1'b0 || bus.resp_p !== '0) begin n_bad++;
            $display("FAIL rst_resp: got v=%0b e=%0b p=%0h want 0 0 0", bus.resp_valid, bus.resp_err, bus.resp_p); end
        n_cmp++; if (bus.mm_a !== '0 || bus.mm_b !== '0 || bus.mm_m !== '0 || grant_id !== 1'b0) begin n_bad++;
            $display("FAIL rst_regs: got a=%0h b=%0h m=%0h gid=%0b want 0", bus.mm_a, bus.mm_b, bus.mm_m, grant_id); end
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++;
            $display("FAIL rst_ready: got %0b want 00", bus.req_ready); end
        @(posedge pclk); #1 reset = 1'b0;
    endtask

    task automatic test_single();
        bit seen; int gc; exp_t e;
        set_req(0, 64'd5, 64'd7, 64'd11);
        wait_accept(20, seen);
        n_cmp++; if (!seen || o_v !== 2'b01) begin n_bad++;
            $display("FAIL t1_accept: got seen=%0b ready=%0b want 1 01", seen, o_v); end
        sb.push_back('{id: 1'b0, p: 65'd12, err: 1'b0});
        wait_resp(40, 2'b01, seen, gc);
        n_cmp++; if (!seen || resp_cyc - acc_cyc !== L + 2) begin n_bad++;
            $display("FAIL t1_latency: got seen=%0b lat=%0d want %0d", seen, resp_cyc - acc_cyc, L + 2); end
        n_cmp++; if (gc !== L + 1) begin n_bad++;
            $display("FAIL t1_go_cycles: got %0d want %0d", gc, L + 1); end
        n_cmp++; if (bus.mm_a !== 64'd5 || bus.mm_b !== 64'd7 || bus.mm_m !== 64'd11 || grant_id !== 1'b0) begin n_bad++;
            $display("FAIL t1_operands: got a=%0d b=%0d m=%0d gid=%0b want 5 7 11 0", bus.mm_a, bus.mm_b, bus.mm_m, grant_id); end
        e = sb.pop_front();
        n_cmp++; if (o_v !== (2'b01 << e.id) || o_p !== e.p || o_e !== e.err) begin n_bad++;
            $display("FAIL t1_result: got v=%0b p=%0d e=%0b want %0b %0d %0b", o_v, o_p, o_e, 2'b01 << e.id, e.p, e.err); end
        @(negedge pclk);
        n_cmp++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0 || bus.resp_p !== 65'd12) begin n_bad++;
            $display("FAIL t1_after: got v=%0b busy=%0b p=%0d want 00 0 12", bus.resp_valid, busy, bus.resp_p); end
    endtask

    task automatic test_round_robin();
        bit seen; int gc; exp_t e; logic w;
        logic [W-1:0] a[2]; logic [W-1:0] b[2];
        reset = 1'b1;
        repeat (2) @(negedge pclk);
        @(posedge pclk); #1 reset = 1'b0;
        a[0] = 64'd1; b[0] = 64'd3; a[1] = 64'd2; b[1] = 64'd5;
        set_req(0, a[0], b[0], 64'd13);
        set_req(1, a[1], b[1], 64'd13);
        for (int r = 0; r < 4; r++) begin
            wait_accept(30, seen);
            n_cmp++; if (!seen || o_which !== r[0]) begin n_bad++;
                $display("FAIL t2_order%0d: got seen=%0b id=%0b want %0b", r, seen, o_which, r[0]); end
            if (r > 0) begin
                n_cmp++; if (acc_cyc !== resp_cyc + 1) begin n_bad++;
                    $display("FAIL t2_b2b%0d: got accept=%0d want %0d", r, acc_cyc, resp_cyc + 1); end
            end
            w = o_which;
            sb.push_back('{id: w, p: {1'b0, W'(a[w] + b[w])}, err: 1'b0});
            wait_resp(40, 2'b00, seen, gc);
            e = sb.pop_front();
            n_cmp++; if (!seen || o_v !== (2'b01 << e.id) || o_p !== e.p || o_e !== e.err) begin n_bad++;
                $display("FAIL t2_result%0d: got v=%0b p=%0d e=%0b want %0b %0d %0b", r, o_v, o_p, o_e, 2'b01 << e.id, e.p, e.err); end
            a[w] = a[w] + 64'd10;
            b[w] = b[w] + 64'd100;
            set_req(int'(w), a[w], b[w], 64'd13);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        bit seen; int gc; exp_t e;
        eng_mode = 1;
        set_req(1, 64'd3, 64'd4, 64'd13);
        wait_accept(20, seen);
        n_cmp++; if (!seen || o_which !== 1'b1) begin n_bad++;
            $display("FAIL t3_accept: got seen=%0b id=%0b want 1 1", seen, o_which); end
        sb.push_back('{id: 1'b1, p: '0, err: 1'b1});
        wait_resp(TO + 40, 2'b10, seen, gc);
        n_cmp++; if (!seen || resp_cyc - acc_cyc !== TO + 2) begin n_bad++;
            $display("FAIL t3_latency: got seen=%0b lat=%0d want %0d", seen, resp_cyc - acc_cyc, TO + 2); end
        n_cmp++; if (gc !== TO + 1) begin n_bad++;
            $display("FAIL t3_go_cycles: got %0d want %0d", gc, TO + 1); end
        e = sb.pop_front();
        n_cmp++; if (o_v !== (2'b01 << e.id) || o_p !== e.p || o_e !== e.err) begin n_bad++;
            $display("FAIL t3_result: got v=%0b p=%0d e=%0b want %0b %0d %0b", o_v, o_p, o_e, 2'b01 << e.id, e.p, e.err); end
        eng_mode = 0;
        set_req(0, 64'd9, 64'd1, 64'd13);
        wait_accept(20, seen);
        sb.push_back('{id: 1'b0, p: 65'd10, err: 1'b0});
        wait_resp(40, 2'b01, seen, gc);
        e = sb.pop_front();
        n_cmp++; if (!seen || resp_cyc - acc_cyc !== L + 2 || o_v !== (2'b01 << e.id) || o_p !== e.p || o_e !== e.err) begin n_bad++;
            $display("FAIL t3_recover: got lat=%0d v=%0b p=%0d e=%0b want %0d %0b %0d %0b", resp_cyc - acc_cyc, o_v, o_p, o_e, L + 2, 2'b01 << e.id, e.p, e.err); end
    endtask

    task automatic test_ready_idle();
        bit seen; int gc; int bad_cyc; exp_t e;
        eng_mode = 2;
        bad_cyc = 0;
        repeat (6) begin
            @(negedge pclk);
            if (bus.resp_valid !== 2'b00 || busy !== 1'b0 || bus.mm_go !== 1'b0) bad_cyc++;
        end
        n_cmp++; if (bad_cyc !== 0) begin n_bad++;
            $display("FAIL t5_idle_ignore: got %0d active cycles want 0", bad_cyc); end
        set_req(0, 64'd20, 64'd22, 64'd13);
        wait_accept(20, seen);
        sb.push_back('{id: 1'b0, p: 65'd42, err: 1'b0});
        wait_resp(20, 2'b01, seen, gc);
        n_cmp++; if (!seen || resp_cyc - acc_cyc !== 2 || gc !== 1) begin n_bad++;
            $display("FAIL t5_first_go: got seen=%0b lat=%0d go=%0d want 1 2 1", seen, resp_cyc - acc_cyc, gc); end
        e = sb.pop_front();
        n_cmp++; if (o_v !== (2'b01 << e.id) || o_p !== e.p || o_e !== e.err) begin n_bad++;
            $display("FAIL t5_result: got v=%0b p=%0d e=%0b want %0b %0d %0b", o_v, o_p, o_e, 2'b01 << e.id, e.p, e.err); end
        eng_mode = 0;
    endtask

    task automatic test_reset_in_run();
        bit seen; int gc; int stray; exp_t e;
        set_req(0, 64'd100, 64'd1, 64'd13);
        wait_accept(20, seen);
        @(negedge pclk);
        bus.req_valid[0] = 1'b0;
        set_req(1, 64'd50, 64'd50, 64'd13);
        stray = 0;
        repeat (3) begin
            @(negedge pclk);
            if (bus.resp_valid !== 2'b00) stray++;
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.mm_go !== 1'b0 || busy !== 1'b0 || bus.resp_valid !== 2'b00 || stray !== 0) begin n_bad++;
            $display("FAIL t4_async: got go=%0b busy=%0b v=%0b stray=%0d want 0 0 00 0", bus.mm_go, busy, bus.resp_valid, stray); end
        repeat (2) @(negedge pclk);
        @(posedge pclk); #1 reset = 1'b0;
        wait_accept(20, seen);
        n_cmp++; if (!seen || o_which !== 1'b1) begin n_bad++;
            $display("FAIL t4_accept: got seen=%0b id=%0b want 1 1", seen, o_which); end
        sb.push_back('{id: 1'b1, p: 65'd100, err: 1'b0});
        wait_resp(40, 2'b10, seen, gc);
        e = sb.pop_front();
        n_cmp++; if (!seen || resp_cyc - acc_cyc !== L + 2 || o_v !== (2'b01 << e.id) || o_p !== e.p || o_e !== e.err) begin n_bad++;
            $display("FAIL t4_result: got lat=%0d v=%0b p=%0d e=%0b want %0d %0b %0d %0b", resp_cyc - acc_cyc, o_v, o_p, o_e, L + 2, 2'b01 << e.id, e.p, e.err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ready_idle();
        test_reset_in_run();
        repeat (3) @(negedge pclk);
        n_cmp++; if (sb.size() !== 0) begin n_bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
